// File: rtl/m_csr_unit_pkg.sv
//------------------------------------------------------------------------------
// m_csr_unit_pkg
// Shared M-mode CSR definitions: addresses, causes, mstatus layout, WARL masks.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package m_csr_unit_pkg;

   typedef enum logic [1:0] {
      CSR_OP_READ  = 2'b00,
      CSR_OP_WRITE = 2'b01,
      CSR_OP_SET   = 2'b10,
      CSR_OP_CLEAR = 2'b11
   } csr_op_e;

   typedef enum logic [11:0] {
      CSR_MSTATUS  = 12'h300,
      CSR_MISA     = 12'h301,
      CSR_MIE      = 12'h304,
      CSR_MTVEC    = 12'h305,
      CSR_MSTATUSH = 12'h310,
      CSR_MSCRATCH = 12'h340,
      CSR_MEPC     = 12'h341,
      CSR_MCAUSE   = 12'h342,
      CSR_MTVAL    = 12'h343,
      CSR_MIP      = 12'h344,
      CSR_MHARTID  = 12'hF14
   } csr_addr_e;

   typedef enum logic [3:0] {
      CAUSE_INSN_MISALIGN  = 4'd0,
      CAUSE_INSN_FAULT     = 4'd1,
      CAUSE_ILLEGAL_INST   = 4'd2,
      CAUSE_BREAKPOINT     = 4'd3,
      CAUSE_LOAD_MISALIGN  = 4'd4,
      CAUSE_LOAD_FAULT     = 4'd5,
      CAUSE_STORE_MISALIGN = 4'd6,
      CAUSE_STORE_FAULT    = 4'd7,
      CAUSE_ECALL_M        = 4'd11
   } exc_cause_e;

   typedef enum logic [3:0] {
      IRQ_MSI = 4'd3,
      IRQ_MTI = 4'd7,
      IRQ_MEI = 4'd11
   } irq_cause_e;

   // Interrupt flag of mcause sits in the top bit for whichever Xlen is in use.
   function automatic logic [63:0] irq_bit(input int unsigned xlen);
      return 64'd1 << (xlen - 1);
   endfunction

   typedef struct packed {
      logic mpie;
      logic mie;
   } mstatus_t;

   localparam int unsigned MSTATUS_MIE_BIT  = 3;
   localparam int unsigned MSTATUS_MPIE_BIT = 7;

   localparam logic [63:0] MSTATUS_WMASK   = 64'h0000_0000_0000_1888;
   localparam logic [63:0] MIE_WMASK       = 64'h0000_0000_0000_0888;
   localparam logic [63:0] MTVEC_BASE_MASK = ~64'h3;

endpackage

`default_nettype wire

// File: rtl/m_csr_unit_irq.sv
//------------------------------------------------------------------------------
// m_irq_arbiter
// Registers the M-level interrupt lines into mip and picks MEI > MSI > MTI.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module m_irq_arbiter
   import m_csr_unit_pkg::*;
#(
   parameter int unsigned Xlen = 64
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            irq_msi_i,
   input  logic            irq_mti_i,
   input  logic            irq_mei_i,
   input  logic [2:0]      mie_i,
   input  logic            mstatus_mie_i,
   output logic [2:0]      mip_o,
   output logic            irq_pending_o,
   output logic [Xlen-1:0] irq_cause_o
);

   localparam logic [63:0] c_irq_bit = irq_bit(Xlen);

   logic [2:0] r_mip;
   logic [2:0] w_act;
   logic [3:0] w_code;

   // Bit order {MEIP, MTIP, MSIP} throughout.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_mip <= 3'b000;
      end else begin
         r_mip <= {irq_mei_i, irq_mti_i, irq_msi_i};
      end
   end

   assign w_act = r_mip & mie_i;

   always_comb begin
      w_code = 4'd0;
      if (w_act[2]) begin
         w_code = IRQ_MEI;
      end else if (w_act[0]) begin
         w_code = IRQ_MSI;
      end else if (w_act[1]) begin
         w_code = IRQ_MTI;
      end
   end

   assign mip_o         = r_mip;
   assign irq_pending_o = mstatus_mie_i & (|w_act);
   assign irq_cause_o   = (|w_act) ? (c_irq_bit[Xlen-1:0] | {{(Xlen-4){1'b0}}, w_code})
                                   : {Xlen{1'b0}};

endmodule

`default_nettype wire

// File: rtl/m_csr_unit.sv
//------------------------------------------------------------------------------
// m_csr_unit
// Machine-mode CSR file with Zicsr access, trap entry / mret sequencing.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module m_csr_unit
   import m_csr_unit_pkg::*;
#(
   parameter int unsigned     Xlen       = 64,
   parameter logic [Xlen-1:0] HartId     = '0,
   parameter logic [Xlen-1:0] MtvecReset = '0,
   parameter bit              VectoredEn = 1'b1
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            csr_valid_i,
   input  logic [1:0]      csr_op_i,
   input  logic [11:0]     csr_addr_i,
   input  logic [Xlen-1:0] csr_wdata_i,
   output logic [Xlen-1:0] csr_rdata_o,
   output logic            csr_illegal_o,
   input  logic            trap_valid_i,
   input  logic [Xlen-1:0] trap_cause_i,
   input  logic [Xlen-1:0] trap_pc_i,
   input  logic [Xlen-1:0] trap_tval_i,
   input  logic            mret_i,
   input  logic            irq_msi_i,
   input  logic            irq_mti_i,
   input  logic            irq_mei_i,
   output logic            irq_pending_o,
   output logic [Xlen-1:0] irq_cause_o,
   output logic            redirect_valid_o,
   output logic [Xlen-1:0] redirect_pc_o
);

   localparam logic [Xlen-1:0] c_low2_mask = MTVEC_BASE_MASK[Xlen-1:0];
   localparam logic [Xlen-1:0] c_misa_ext  = {{(Xlen-13){1'b0}}, 13'h1100};

   mstatus_t        r_mstatus;
   logic [Xlen-1:0] r_mtvec, r_mepc, r_mcause, r_mtval, r_mscratch, r_mie;
   logic            r_redirect_valid;
   logic [Xlen-1:0] r_redirect_pc;

   csr_op_e         w_op;
   logic [2:0]      w_mip;
   logic [Xlen-1:0] w_misa, w_mstatus_rd, w_mip_rd, w_old, w_wval;
   logic [Xlen-1:0] w_mtvec_new, w_base, w_trap_target;
   logic            w_mstatush_ok, w_hit, w_we, w_mode_ok, w_vectored;

   generate
      if (Xlen == 32) begin : g_misa32
         assign w_misa        = {2'b01, {(Xlen-2){1'b0}}} | c_misa_ext;
         assign w_mstatush_ok = 1'b1;
      end else begin : g_misa64
         assign w_misa        = {2'b10, {(Xlen-2){1'b0}}} | c_misa_ext;
         assign w_mstatush_ok = 1'b0;
      end
   endgenerate

   assign w_op         = csr_op_e'(csr_op_i);
   assign w_mstatus_rd = {{(Xlen-13){1'b0}}, 2'b11, 3'b000, r_mstatus.mpie, 3'b000,
                          r_mstatus.mie, 3'b000};

   always_comb begin
      w_mip_rd     = '0;
      w_mip_rd[3]  = w_mip[0];
      w_mip_rd[7]  = w_mip[1];
      w_mip_rd[11] = w_mip[2];
   end

   always_comb begin
      w_old = '0;
      w_hit = 1'b1;
      case (csr_addr_i)
         CSR_MHARTID:  w_old = HartId;
         CSR_MISA:     w_old = w_misa;
         CSR_MSTATUS:  w_old = w_mstatus_rd;
         CSR_MSTATUSH: w_hit = w_mstatush_ok;
         CSR_MTVEC:    w_old = r_mtvec;
         CSR_MIE:      w_old = r_mie;
         CSR_MIP:      w_old = w_mip_rd;
         CSR_MSCRATCH: w_old = r_mscratch;
         CSR_MEPC:     w_old = r_mepc;
         CSR_MCAUSE:   w_old = r_mcause;
         CSR_MTVAL:    w_old = r_mtval;
         default:      w_hit = 1'b0;
      endcase
   end

   always_comb begin
      w_wval = w_old;
      case (w_op)
         CSR_OP_WRITE: w_wval = csr_wdata_i;
         CSR_OP_SET:   w_wval = w_old | csr_wdata_i;
         CSR_OP_CLEAR: w_wval = w_old & ~csr_wdata_i;
         default:      w_wval = w_old;
      endcase
   end

   assign csr_rdata_o   = w_old;
   assign csr_illegal_o = csr_valid_i &
                          (~w_hit | ((w_op != CSR_OP_READ) && (csr_addr_i[11:10] == 2'b11)));
   // Trap and mret outrank a CSR write in the same cycle; the write is simply lost.
   assign w_we = csr_valid_i & ~csr_illegal_o & (w_op != CSR_OP_READ) & ~trap_valid_i & ~mret_i;

   assign w_mode_ok   = (w_wval[1:0] == 2'b00) | ((w_wval[1:0] == 2'b01) & VectoredEn);
   assign w_mtvec_new = (w_wval & c_low2_mask) |
                        {{(Xlen-2){1'b0}}, (w_mode_ok ? w_wval[1:0] : r_mtvec[1:0])};

   assign w_base        = r_mtvec & c_low2_mask;
   assign w_vectored    = trap_cause_i[Xlen-1] & (r_mtvec[1:0] == 2'b01);
   assign w_trap_target = w_vectored ? (w_base + {trap_cause_i[Xlen-3:0], 2'b00}) : w_base;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_mstatus        <= '0;
         r_mtvec          <= MtvecReset & c_low2_mask;
         r_mepc           <= '0;
         r_mcause         <= '0;
         r_mtval          <= '0;
         r_mscratch       <= '0;
         r_mie            <= '0;
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= '0;
      end else begin
         r_redirect_valid <= trap_valid_i | mret_i;
         if (trap_valid_i) begin
            r_mepc         <= trap_pc_i & c_low2_mask;
            r_mcause       <= trap_cause_i;
            r_mtval        <= trap_tval_i;
            r_mstatus.mpie <= r_mstatus.mie;
            r_mstatus.mie  <= 1'b0;
            r_redirect_pc  <= w_trap_target;
         end else if (mret_i) begin
            r_mstatus.mie  <= r_mstatus.mpie;
            r_mstatus.mpie <= 1'b1;
            r_redirect_pc  <= r_mepc;
         end else if (w_we) begin
            case (csr_addr_i)
               CSR_MSTATUS: begin
                  r_mstatus.mie  <= w_wval[MSTATUS_MIE_BIT] & MSTATUS_WMASK[MSTATUS_MIE_BIT];
                  r_mstatus.mpie <= w_wval[MSTATUS_MPIE_BIT] & MSTATUS_WMASK[MSTATUS_MPIE_BIT];
               end
               CSR_MTVEC:    r_mtvec    <= w_mtvec_new;
               CSR_MIE:      r_mie      <= w_wval & MIE_WMASK[Xlen-1:0];
               CSR_MSCRATCH: r_mscratch <= w_wval;
               CSR_MEPC:     r_mepc     <= w_wval & c_low2_mask;
               CSR_MCAUSE:   r_mcause   <= w_wval;
               CSR_MTVAL:    r_mtval    <= w_wval;
               default:      ;
            endcase
         end
      end
   end

   assign redirect_valid_o = r_redirect_valid;
   assign redirect_pc_o    = r_redirect_pc;

   m_irq_arbiter #(
      .Xlen (Xlen)
   ) u_irq_arbiter (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .irq_msi_i     (irq_msi_i),
      .irq_mti_i     (irq_mti_i),
      .irq_mei_i     (irq_mei_i),
      .mie_i         ({r_mie[11], r_mie[7], r_mie[3]}),
      .mstatus_mie_i (r_mstatus.mie),
      .mip_o         (w_mip),
      .irq_pending_o (irq_pending_o),
      .irq_cause_o   (irq_cause_o)
   );

endmodule

`default_nettype wire
